// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB PWM output path.
// Colour constants are full-scale (8'hFF) duty triples at the default resolution.
package rgb_pkg;

    localparam int DEFAULT_PWM_BITS = 8;

    typedef struct packed {
        logic [DEFAULT_PWM_BITS-1:0] r;
        logic [DEFAULT_PWM_BITS-1:0] g;
        logic [DEFAULT_PWM_BITS-1:0] b;
    } rgb_duty_t;

    localparam rgb_duty_t RED     = '{r: 8'hFF, g: 8'h00, b: 8'h00};
    localparam rgb_duty_t YELLOW  = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
    localparam rgb_duty_t GREEN   = '{r: 8'h00, g: 8'hFF, b: 8'h00};
    localparam rgb_duty_t CYAN    = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
    localparam rgb_duty_t BLUE    = '{r: 8'h00, g: 8'h00, b: 8'hFF};
    localparam rgb_duty_t MAGENTA = '{r: 8'hFF, g: 8'h00, b: 8'hFF};
    localparam rgb_duty_t OFF     = '{r: 8'h00, g: 8'h00, b: 8'h00};

    // Clocks per PWM step, never less than one.
    function automatic int calc_prescale(input int clk_freq, input int pwm_freq, input int pwm_bits);
        int p;
        p = clk_freq / (pwm_freq * (1 << pwm_bits));
        return (p < 1) ? 1 : p;
    endfunction

endpackage

// File: rtl/rgb_pwm_driver_timebase.sv
// pwm_timebase: prescaler plus PWM period counter.
// step pulses once every PRESCALE clocks; wrap marks the last clock of a period.
module pwm_timebase #(
    parameter int PRESCALE = 4,
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                step,
    output logic                wrap
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]    PRE_MAX = PRE_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    logic [PRE_W-1:0] pre_cnt;

    assign step = (pre_cnt == PRE_MAX);
    assign wrap = step && (pwm_cnt == CNT_MAX);

    // Prescaler and period counter; the period counter wraps naturally at 2**PWM_BITS.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else if (step) begin
            pre_cnt <= '0;
            pwm_cnt <= pwm_cnt + 1'b1;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: three-channel synchronous PWM with a double-buffered duty triple.
// New duties land in a shadow buffer and are copied to the active set only at a
// period boundary, so every period on the pins is a complete, consistent one.
// Build option RGB_PWM_ACTIVE_LOW_EN inverts the pins for common-anode LEDs.
module rgb_pwm_driver
    import rgb_pkg::*;
#(
    parameter int CLK_FREQ = 12000000,
    parameter int PWM_FREQ = 2000,
    parameter int PWM_BITS = DEFAULT_PWM_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] duty_r,
    input  logic [PWM_BITS-1:0] duty_g,
    input  logic [PWM_BITS-1:0] duty_b,
    input  logic                duty_valid,
    output logic                duty_ready,
    output logic                period_start,
    output logic                red,
    output logic                green,
    output logic                blue
);

    localparam int PRESCALE = calc_prescale(CLK_FREQ, PWM_FREQ, PWM_BITS);

    typedef struct packed {
        logic [PWM_BITS-1:0] r;
        logic [PWM_BITS-1:0] g;
        logic [PWM_BITS-1:0] b;
    } duty_t;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic                step;
    logic                wrap;
    duty_t               shadow;
    duty_t               active;
    logic                pending;
    logic                led_r;
    logic                led_g;
    logic                led_b;

    pwm_timebase #(
        .PRESCALE (PRESCALE),
        .PWM_BITS (PWM_BITS)
    ) u_timebase (
        .clk     (clk),
        .rst_n   (rst_n),
        .pwm_cnt (pwm_cnt),
        .step    (step),
        .wrap    (wrap)
    );

    assign duty_ready = !pending;

    // Double buffer: apply at the period boundary, otherwise accept into shadow.
    // Apply needs pending=1 and accept needs pending=0, so they never collide;
    // an accept on the wrap cycle waits for the following boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else if (wrap && pending) begin
            active  <= shadow;
            pending <= 1'b0;
        end else if (duty_valid && !pending) begin
            shadow  <= '{r: duty_r, g: duty_g, b: duty_b};
            pending <= 1'b1;
        end else begin
            pending <= pending;
        end
    end

    // Registered period strobe and channel comparators (one clock behind the counter).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_start <= 1'b0;
            led_r        <= 1'b0;
            led_g        <= 1'b0;
            led_b        <= 1'b0;
        end else begin
            period_start <= wrap;
            led_r        <= (pwm_cnt < active.r);
            led_g        <= (pwm_cnt < active.g);
            led_b        <= (pwm_cnt < active.b);
        end
    end

`ifdef RGB_PWM_ACTIVE_LOW_EN
    assign red   = ~led_r;
    assign green = ~led_g;
    assign blue  = ~led_b;
`else
    assign red   = led_r;
    assign green = led_g;
    assign blue  = led_b;
`endif

    // step is consumed only inside the timebase's wrap term here.
    logic unused_step;
    assign unused_step = step;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Self-checking bench for rgb_pwm_driver (CLK_FREQ=1024, PWM_FREQ=1 -> 4 clocks/step,
// 1024 clocks/period). A clock-position model predicts every output on every cycle;
// literal lit-time counts and latencies pin the model.
module tb_rgb_pwm_driver;

    localparam int PER  = 1024;
    localparam int STEP = PER / 256;
`ifdef RGB_PWM_ACTIVE_LOW_EN
    localparam logic LIT = 1'b0;
`else
    localparam logic LIT = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] duty_r = 8'd0;
    logic [7:0] duty_g = 8'd0;
    logic [7:0] duty_b = 8'd0;
    logic       duty_valid = 1'b0;
    logic       duty_ready;
    logic       period_start;
    logic       red;
    logic       green;
    logic       blue;

    always #5 clk = ~clk;

    rgb_pwm_driver #(
        .CLK_FREQ (1024),
        .PWM_FREQ (1),
        .PWM_BITS (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .duty_r       (duty_r),
        .duty_g       (duty_g),
        .duty_b       (duty_b),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .period_start (period_start),
        .red          (red),
        .green        (green),
        .blue         (blue)
    );

    int tests = 0;
    int fails = 0;

    // Model: ph = clock position within the period (0..PER-1) held by the DUT.
    bit mvalid = 1'b0;
    int ph = 0;
    bit pend = 1'b0;
    int sh[3];
    int act[3];
    bit e_ps = 1'b0;
    bit e_led[3];

    task automatic check(input string name, input logic got, input logic exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit last;
        if (!rst_n) begin
            mvalid = 1'b1;
            ph = 0;
            pend = 1'b0;
            e_ps = 1'b0;
            for (int i = 0; i < 3; i++) begin
                sh[i] = 0;
                act[i] = 0;
                e_led[i] = 1'b0;
            end
        end else if (mvalid) begin
            last = (ph == PER - 1);
            for (int i = 0; i < 3; i++) e_led[i] = ((ph / STEP) < act[i]);
            e_ps = last;
            if (last && pend) begin
                for (int i = 0; i < 3; i++) act[i] = sh[i];
                pend = 1'b0;
            end else if (duty_valid && !pend) begin
                sh[0] = int'(duty_r);
                sh[1] = int'(duty_g);
                sh[2] = int'(duty_b);
                pend = 1'b1;
            end
            ph = (ph + 1) % PER;
        end
    endtask

    task automatic check_all();
        if (mvalid) begin
            check("duty_ready", duty_ready, !pend);
            check("period_start", period_start, e_ps);
            check("red", red, e_led[0] ? LIT : !LIT);
            check("green", green, e_led[1] ? LIT : !LIT);
            check("blue", blue, e_led[2] ? LIT : !LIT);
        end
    endtask

    // One clock: advance the model on the edge, compare just after it.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic wait_ps(output int n);
        n = 0;
        for (int i = 0; i < 1100; i++) begin
            cycle();
            n++;
            if (period_start === 1'b1) return;
        end
        tests++;
        fails++;
        $display("FAIL wait_period_start: no strobe within 1100 cycles, required one");
    endtask

    task automatic count_period(output int cr, output int cg, output int cb);
        cr = 0; cg = 0; cb = 0;
        for (int i = 0; i < PER; i++) begin
            cycle();
            if (red === LIT) cr++;
            if (green === LIT) cg++;
            if (blue === LIT) cb++;
        end
    endtask

    task automatic offer(input int r, input int g, input int b);
        duty_r = 8'(r);
        duty_g = 8'(g);
        duty_b = 8'(b);
        duty_valid = 1'b1;
    endtask

    initial begin
        int n;
        int cr, cg, cb;
        int cr2, cg2, cb2;

        // Reset held with a triple offered: nothing may be accepted or lit.
        rst_n = 1'b0;
        offer(99, 88, 77);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("rst_red", red, !LIT);
            check("rst_green", green, !LIT);
            check("rst_blue", blue, !LIT);
            check("rst_ready", duty_ready, 1'b1);
            check("rst_period_start", period_start, 1'b0);
        end
        rst_n = 1'b1;
        duty_valid = 1'b0;
        wait_ps(n);
        check_int("first_period_start_latency", n, 1024);

        // Duty accept at cycle 10 of the period.
        repeat (10) cycle();
        offer(64, 0, 255);
        cycle();
        duty_valid = 1'b0;
        check("ready_low_after_accept", duty_ready, 1'b0);
        wait_ps(n);
        check("ready_back_after_apply", duty_ready, 1'b1);
        count_period(cr, cg, cb);
        check_int("accept_red_lit", cr, 256);
        check_int("accept_green_lit", cg, 0);
        check_int("accept_blue_lit", cb, 1020);

        // Back-pressure: a second triple is held off while one is pending.
        offer(77, 33, 200);
        cycle();
        offer(128, 128, 128);
        for (int i = 0; i < 50; i++) begin
            cycle();
            check("bp_ready_low", duty_ready, 1'b0);
        end
        for (int i = 0; i < 1100; i++) begin
            cycle();
            if (duty_ready === 1'b1) break;
        end
        cycle();
        duty_valid = 1'b0;
        check("bp_accepted", duty_ready, 1'b0);
        wait_ps(n);
        count_period(cr, cg, cb);
        check_int("bp_red_lit", cr, 512);
        check_int("bp_green_lit", cg, 512);
        check_int("bp_blue_lit", cb, 512);

        // Accept exactly on the wrap cycle: applied one full period later.
        for (int i = 0; i < 1100; i++) begin
            if (ph == PER - 1) break;
            cycle();
        end
        offer(10, 20, 30);
        cycle();
        duty_valid = 1'b0;
        check("wrap_accept_strobe", period_start, 1'b1);
        check("wrap_accept_pending", duty_ready, 1'b0);
        count_period(cr, cg, cb);
        check_int("wrap_old_red_lit", cr, 512);
        count_period(cr, cg, cb);
        check_int("wrap_new_red_lit", cr, 40);
        check_int("wrap_new_green_lit", cg, 80);
        check_int("wrap_new_blue_lit", cb, 120);

        // Reset mid-period with a pending shadow value: it must be discarded.
        offer(200, 200, 200);
        cycle();
        duty_valid = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            if (ph / STEP == 100) break;
            cycle();
        end
        rst_n = 1'b0;
        cycle();
        cycle();
        check("midrst_red", red, !LIT);
        check("midrst_ready", duty_ready, 1'b1);
        rst_n = 1'b1;
        count_period(cr, cg, cb);
        count_period(cr2, cg2, cb2);
        check_int("midrst_lit_total", cr + cg + cb + cr2 + cg2 + cb2, 0);

        // Randomized traffic; the source holds its data while not accepted.
        for (int i = 0; i < 6000; i++) begin
            if (!(duty_valid && !duty_ready)) begin
                duty_r = 8'($urandom_range(0, 255));
                duty_g = 8'($urandom_range(0, 255));
                duty_b = 8'($urandom_range(0, 255));
                duty_valid = ($urandom_range(0, 63) == 0);
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
Downstream output stage for the colour-cycling FSM. It accepts a per-channel RGB duty triple over a valid/ready handshake and drives the three LED pins with synchronous PWM. This gives dimming and mixed colours instead of plain on/off. Duty updates are double-buffered and applied only at a PWM period boundary, so no glitched periods ever reach the pins.

Parameters:
CLK_FREQ, 12000000, system clock frequency in Hz
PWM_FREQ, 2000, target PWM period rate in Hz
PWM_BITS, 8, duty resolution; period = 2**PWM_BITS steps
PRESCALE, derived localparam = CLK_FREQ/(PWM_FREQ*2**PWM_BITS), clocks per PWM step (minimum 1; 23 at defaults)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
duty_r  input  PWM_BITS  red duty, on-steps per period
duty_g  input  PWM_BITS  green duty
duty_b  input  PWM_BITS  blue duty
duty_valid  input  1  duty triple offered this cycle
duty_ready  output  1  shadow buffer free; triple accepted when duty_valid && duty_ready
period_start  output  1  one-cycle strobe on the first cycle of each PWM period
red  output  1  red LED drive
green  output  1  green LED drive
blue  output  1  blue LED drive

Behaviour:
- Reset (rst_n low at a clk edge): pre_cnt=0, pwm_cnt=0, active and shadow duties=0, pending=0, period_start=0, red/green/blue=0 (LED off). Reset mid-period abandons the period; an unapplied shadow value is discarded.
- Timebase: pre_cnt counts 0..PRESCALE-1. step = (pre_cnt==PRESCALE-1). pwm_cnt increments on step and wraps from 2**PWM_BITS-1 to 0. wrap = step && pwm_cnt==2**PWM_BITS-1.
- Handshake: duty_ready = !pending (combinational from the register). On accept, shadow <= {duty_r,duty_g,duty_b} and pending <= 1. duty_valid without ready is ignored, and the source must hold its data.
- Apply: on wrap with pending=1, active <= shadow and pending <= 0. duty_ready goes high on the following cycle.
- Accept on the wrap cycle itself (pending was 0): the value goes to shadow and is applied at the next wrap, not the current one.
- period_start is registered and equals 1 on the cycle after wrap, i.e. the first cycle with pwm_cnt=0.
- Outputs are registered: red <= (pwm_cnt < active_r), and likewise for green and blue. This is one clock of latency from the counter.
  - Duty 0 means always off.
  - Duty 2**PWM_BITS-1 means on for 255 of 256 steps.
- Width rules: the comparison is unsigned at PWM_BITS, and there is no arithmetic on duty values.
- Channels are independent and all switch together at pwm_cnt=0.

Optional Feature:
RGB_PWM_ACTIVE_LOW_EN
- Defined: red/green/blue are inverted after the output register. They reset to 1, and an LED is lit when its pin is 0, which suits the common-anode board LEDs.
- Undefined: outputs are active-high and reset to 0, as described above.
- Handshake, timing and period_start are identical in both builds.

Decomposition:
- Package rgb_pkg holds:
  - typedef rgb_duty_t, a packed struct {r,g,b} of PWM_BITS each;
  - DEFAULT_PWM_BITS=8;
  - colour-constant duty triples RED, YELLOW, GREEN, CYAN, BLUE, MAGENTA, OFF at full scale 8'hFF.
- One sub-module is natural: pwm_timebase (prescaler plus period counter, producing pwm_cnt, step and wrap). It is reusable by later fade/breathing blocks.
- The comparators and the double buffer stay in rgb_pwm_driver.

Test Plan:
- All tests use CLK_FREQ=1024, PWM_FREQ=1, giving PRESCALE=4 and a period of 1024 clocks.
- Reset: hold rst_n=0 for 3 cycles with duty_valid=1 → red=green=blue=0, duty_ready=1 and period_start=0 throughout; first period_start occurs 1024 cycles after release.
- Duty accept: offer {64,0,255} at cycle 10 → duty_ready=0 from cycle 11. At the first wrap, active updates and duty_ready returns 1. Over the next period, red is high for 256 clocks, green for 0 and blue for 1020, each high run starting the cycle after period_start.
- Back-pressure: while pending, offer {128,128,128} for 50 cycles → not accepted and active unchanged. It is accepted on the first cycle duty_ready=1 after the wrap, and applied at the following wrap.
- Accept on wrap cycle: offer {10,20,30} exactly on the wrap cycle → not applied to the period starting next; applied one full period later.
- Reset mid-period: set pending, assert rst_n=0 at pwm_cnt=100 → outputs 0 and pending cleared. After release, duty 0 persists (the shadow value is never applied).
- RGB_PWM_ACTIVE_LOW_EN build: repeat the duty-accept test → pins are the exact complement, reset value 1, and period_start timing is unchanged.
